// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch/decode definitions: reset PC, NOP encoding, opcodes and the queue entry layout.
package instr_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // One prefetch queue entry: PC tag alongside the fetched word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [2:0] instr_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [6:0] instr_funct7(input logic [31:0] instr);
    return instr[31:25];
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus bundle: instruction memory request/response, EX redirect and decode handshake.
interface instr_fetch_queue_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  // Memory / EX / decode side.
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO with flush; read data is the head entry, visible combinationally.
module instr_fetch_queue_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry storage, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch: PC generation, credit-limited imem requests, prefetch queue toward decode.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_queue_if.master bus
);

  localparam int unsigned     CntW      = $clog2(DEPTH) + 1;
  localparam logic [CntW+1:0] CreditMax = (CntW+2)'(DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] q_count, tag_count;
  logic [CntW+1:0] credit_used;
  logic            req, grant, resp_keep, resp_drop, if_valid_int, pop;
  logic            q_empty, q_full, tag_empty, tag_full;
  logic [31:0]     tag_pc;
  fetch_entry_t    q_wdata, q_rdata;
  logic            unused_status;

  // Every slot is reserved at grant time, so an accepted response always finds room.
  assign credit_used = {2'b00, q_count} + {2'b00, outstanding_q} + {2'b00, discard_q};
  assign req         = !rst && !bus.redirect_valid && (credit_used < CreditMax);
  assign grant       = req && bus.imem_gnt;
  assign resp_drop   = bus.imem_rvalid && (discard_q != '0);
  assign resp_keep   = bus.imem_rvalid && (discard_q == '0);

  assign if_valid_int = !q_empty && !rst;
  assign pop          = if_valid_int && bus.if_ready;

  assign q_wdata.pc    = tag_pc;
  assign q_wdata.instr = bus.imem_rdata;

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_int;
  assign bus.if_instr  = q_rdata.instr;
  assign bus.if_pc     = q_rdata.pc;

  assign unused_status = ^{q_full, tag_empty, tag_full, tag_count};

  // PC tags of granted requests, matched in order against kept responses.
  instr_fetch_queue_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (grant),
    .wdata (pc_q),
    .pop   (resp_keep),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Prefetch queue of {pc, instr} entries feeding decode.
  instr_fetch_queue_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (resp_keep),
    .wdata (q_wdata),
    .pop   (pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Next PC and credit bookkeeping; a redirect turns all in-flight requests into discards.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (bus.redirect_valid) begin
      pc_d          = bus.redirect_pc & ~32'h3;
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q - CntW'(bus.imem_rvalid);
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      outstanding_d = outstanding_q + CntW'(grant) - CntW'(resp_keep);
      discard_d     = discard_q - CntW'(resp_drop);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order, variable-latency instruction memory.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_queue_if bus();

  instr_fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Memory model state.
  logic [31:0] rq_addr[$];
  int unsigned rq_due[$];
  int unsigned edge_no = 0;
  int unsigned last_due = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned n_grants = 0;
  int          gnt_mode = 1;  // 0 never, 1 always, 2 random
  logic [31:0] exp_pc;
  int unsigned pops;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h1357_9bdf) * 32'h0001_0003) + INSTR_NOP;
  endfunction

  // Responder: decides rvalid/gnt for the upcoming rising edge, responses strictly in order.
  always @(negedge clk) begin
    int unsigned due;
    if (rst) begin
      rq_addr.delete();
      rq_due.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.imem_gnt    = 1'b0;
      n_grants        = 0;
      last_due        = 0;
    end else begin
      if (rq_due.size() > 0 && rq_due[0] <= edge_no) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(rq_addr[0]);
        void'(rq_addr.pop_front());
        void'(rq_due.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
      end
      case (gnt_mode)
        0:       bus.imem_gnt = 1'b0;
        1:       bus.imem_gnt = 1'b1;
        default: bus.imem_gnt = 1'($urandom_range(1, 0));
      endcase
      if (bus.imem_req && bus.imem_gnt) begin
        due = edge_no + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        rq_addr.push_back(bus.imem_addr);
        rq_due.push_back(due);
        last_due = due;
        n_grants++;
      end
    end
    edge_no++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b0;
    gnt_mode = 1;
    lat_min  = 1;
    lat_max  = 1;
    step();
    step();
    rst    = 1'b0;
    exp_pc = 32'h0;
    pops   = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b1;
    gnt_mode = 1;
    step();
    step();
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_req: got %b want 0", bus.imem_req);
    end
    n_vec++;
    if (bus.if_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid);
    end
    n_vec++;
    if (bus.imem_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_addr: got %h want 00000000", bus.imem_addr);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b1) begin
      n_err++; $display("FAIL release_req: got %b want 1", bus.imem_req);
    end
    step();
  endtask

  task automatic test_stream();
    do_reset();
    bus.if_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin
      n_err++; $display("FAIL stream_w0: got addr %h req %b want 0 1", bus.imem_addr, bus.imem_req);
    end
    step();
    #1;
    n_vec++;
    if (bus.imem_addr !== 32'h4 || bus.if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_w1: got addr %h valid %b want 4 0", bus.imem_addr, bus.if_valid);
    end
    step();
    for (int i = 0; i < 12; i++) begin
      #1;
      n_vec++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin
        n_err++;
        $display("FAIL stream_pop: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", bus.if_valid,
                 bus.if_pc, bus.if_instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 4;
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i >= 2) begin
        n_vec++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== mem_word(32'h0)) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b pc=%h ins=%h want 1 00000000 %h", bus.if_valid,
                   bus.if_pc, bus.if_instr, mem_word(32'h0));
        end
      end
      if (i >= 5) begin
        n_vec++;
        if (bus.imem_req !== 1'b0) begin
          n_err++; $display("FAIL stall_req: got %b want 0", bus.imem_req);
        end
      end
      step();
    end
    n_vec++;
    if (n_grants !== 4) begin
      n_err++; $display("FAIL stall_grants: got %0d want 4", n_grants);
    end
    bus.if_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_vec++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin
        n_err++;
        $display("FAIL stall_resume: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", bus.if_valid,
                 bus.if_pc, bus.if_instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 4;
      step();
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    step();
    step();
    lat_min = 3;
    lat_max = 3;
    step();
    step();
    gnt_mode = 0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b1) begin
      n_err++;
      $display("FAIL redir_cycle: got req %b valid %b want 0 1", bus.imem_req, bus.if_valid);
    end
    step();
    bus.redirect_valid = 1'b0;
    gnt_mode = 1;
    lat_min  = 1;
    lat_max  = 1;
    bus.if_ready = 1'b1;
    exp_pc = 32'h0000_0100;
    #1;
    n_vec++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL redir_after: got valid %b addr %h want 0 00000100", bus.if_valid,
               bus.imem_addr);
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) #1;
      if (bus.if_valid && bus.if_ready) begin
        n_vec++;
        if (bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin
          n_err++;
          $display("FAIL redir_stream: got pc=%h ins=%h want pc=%h ins=%h", bus.if_pc,
                   bus.if_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
        pops++;
      end
      step();
    end
    n_vec++;
    if (pops < 6) begin
      n_err++; $display("FAIL redir_progress: got %0d pops want >= 6", pops);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    bus.if_ready = 1'b1;
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
      end
      #1;
      if (bus.if_valid) begin
        n_vec++;
        if (bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin
          n_err++;
          $display("FAIL rv_pre: got pc=%h ins=%h want pc=%h ins=%h", bus.if_pc, bus.if_instr,
                   exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
      end
      if (i == 8) begin
        #4;
        n_vec++;
        if (bus.imem_rvalid !== 1'b1) begin
          n_err++; $display("FAIL rv_coincide: got rvalid %b want 1", bus.imem_rvalid);
        end
      end
      step();
    end
    bus.redirect_valid = 1'b0;
    exp_pc = 32'h0000_0200;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.if_valid) begin
        n_vec++;
        if (bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin
          n_err++;
          $display("FAIL rv_post: got pc=%h ins=%h want pc=%h ins=%h", bus.if_pc, bus.if_instr,
                   exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
        pops++;
      end
      step();
    end
    n_vec++;
    if (dut.discard_q !== '0 || pops < 5) begin
      n_err++; $display("FAIL rv_drain: got discard %0d pops %0d want 0 >=5", dut.discard_q, pops);
    end
  endtask

  task automatic test_random();
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_ins;
    do_reset();
    gnt_mode = 2;
    lat_min  = 1;
    lat_max  = 3;
    prev_stall = 1'b0;
    prev_pc    = 32'h0;
    prev_ins   = 32'h0;
    for (int i = 0; i < 300; i++) begin
      bus.if_ready = 1'($urandom_range(1, 0));
      #1;
      if (prev_stall) begin
        n_vec++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== prev_pc || bus.if_instr !== prev_ins) begin
          n_err++;
          $display("FAIL rnd_hold: got v=%b pc=%h ins=%h want 1 %h %h", bus.if_valid, bus.if_pc,
                   bus.if_instr, prev_pc, prev_ins);
        end
      end
      if (bus.if_valid && bus.if_ready) begin
        n_vec++;
        if (bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin
          n_err++;
          $display("FAIL rnd_stream: got pc=%h ins=%h want pc=%h ins=%h", bus.if_pc,
                   bus.if_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
        pops++;
      end
      prev_stall = bus.if_valid && !bus.if_ready;
      prev_pc    = bus.if_pc;
      prev_ins   = bus.if_instr;
      step();
    end
    n_vec++;
    if (pops < 30) begin
      n_err++; $display("FAIL rnd_progress: got %0d pops want >= 30", pops);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 8; i++) step();
    #1;
    n_vec++;
    if (bus.if_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL mid_full: got v=%b req=%b addr=%h want 1 0 00000010", bus.if_valid,
               bus.imem_req, bus.imem_addr);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst: got v=%b req=%b want 0 0", bus.if_valid, bus.imem_req);
    end
    step();
    rst = 1'b0;
    bus.if_ready = 1'b1;
    exp_pc = 32'h0;
    #1;
    n_vec++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL mid_restart: got v=%b addr=%h req=%b want 0 00000000 1", bus.if_valid,
               bus.imem_addr, bus.imem_req);
    end
    step();
    #1;
    n_vec++;
    if (bus.if_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_latency: got v=%b want 0", bus.if_valid);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_vec++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin
        n_err++;
        $display("FAIL mid_stream: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", bus.if_valid,
                 bus.if_pc, bus.if_instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 4;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.if_ready       = 1'b0;
    step();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
